// File: rtl/e_stage_reg_pkg.sv
// Shared Y86 constants and E-stage helpers used by the execute pipeline register.
package e_stage_reg_pkg;

   // Y86 instruction codes
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [3:0] ICODE_JXX = 4'h7;

   // Y86 status codes
   localparam logic [3:0] STAT_AOK  = 4'h1;
   localparam logic [3:0] STAT_HLT  = 4'h2;
   localparam logic [3:0] STAT_ADR  = 4'h3;
   localparam logic [3:0] STAT_INS  = 4'h4;

   // "No register" identifier
   localparam logic [3:0] RNONE     = 4'hF;

   // Which way the E register is updated on a non-reset edge
   typedef enum logic [1:0] {
      PATH_LOAD   = 2'd0,
      PATH_BUBBLE = 2'd1,
      PATH_STALL  = 2'd2
   } e_path_t;

   // An instruction entering E behind a not-taken jump is on the mispredicted
   // path; its exception status must not reach later stages.
   function automatic logic squash_stat(input logic [3:0] m_icode,
                                        input logic       cnd,
                                        input logic [3:0] stat);
      return (m_icode == ICODE_JXX) && (cnd == 1'b0) && (stat != STAT_AOK);
   endfunction

endpackage

// File: rtl/e_stage_reg_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   output logic [CW-1:0] count
);

   logic [CW-1:0] r_count;

   // Count up on inc unless already at the maximum value; clear on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= {CW{1'b0}};
      end else if (inc && (r_count != {CW{1'b1}})) begin
         r_count <= r_count + CW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/e_stage_reg.sv
// Y86 execute-stage pipeline register with stall/bubble control, mispredict
// status squashing and saturating bubble/stall/squash event counters.
module e_stage_reg
   import e_stage_reg_pkg::*;
#(
   parameter int W  = 64,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          E_stall,
   input  logic          E_bubble,
   input  logic [3:0]    d_stat,
   input  logic [3:0]    d_icode,
   input  logic [3:0]    d_ifun,
   input  logic [W-1:0]  d_valC,
   input  logic [W-1:0]  d_valA,
   input  logic [W-1:0]  d_valB,
   input  logic [3:0]    d_dstE,
   input  logic [3:0]    d_dstM,
   input  logic [3:0]    d_srcA,
   input  logic [3:0]    d_srcB,
   input  logic [3:0]    M_icode,
   input  logic          e_Cnd,
   output logic [3:0]    E_stat,
   output logic [3:0]    E_icode,
   output logic [3:0]    E_ifun,
   output logic [W-1:0]  E_valC,
   output logic [W-1:0]  E_valA,
   output logic [W-1:0]  E_valB,
   output logic [3:0]    E_dstE,
   output logic [3:0]    E_dstM,
   output logic [3:0]    E_srcA,
   output logic [3:0]    E_srcB,
   output logic          E_valid,
   output logic [CW-1:0] bubble_cnt,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] squash_cnt
);

   e_path_t      w_path;
   logic         w_squash;
   logic         w_inc_bubble;
   logic         w_inc_stall;
   logic         w_inc_squash;

   logic [3:0]   w_next_stat;
   logic [3:0]   w_next_icode;
   logic [3:0]   w_next_ifun;
   logic [W-1:0] w_next_valC;
   logic [W-1:0] w_next_valA;
   logic [W-1:0] w_next_valB;
   logic [3:0]   w_next_dstE;
   logic [3:0]   w_next_dstM;
   logic [3:0]   w_next_srcA;
   logic [3:0]   w_next_srcB;
   logic         w_next_valid;

   logic [3:0]   r_stat;
   logic [3:0]   r_icode;
   logic [3:0]   r_ifun;
   logic [W-1:0] r_valC;
   logic [W-1:0] r_valA;
   logic [W-1:0] r_valB;
   logic [3:0]   r_dstE;
   logic [3:0]   r_dstM;
   logic [3:0]   r_srcA;
   logic [3:0]   r_srcB;
   logic         r_valid;

   // Select the update path (stall beats bubble) and derive event pulses;
   // no event is counted on a reset edge
   always_comb begin
      w_path       = PATH_LOAD;
      w_squash     = 1'b0;
      w_inc_bubble = 1'b0;
      w_inc_stall  = 1'b0;
      w_inc_squash = 1'b0;
      if (E_stall) begin
         w_path = PATH_STALL;
      end else if (E_bubble) begin
         w_path = PATH_BUBBLE;
      end else begin
         w_path = PATH_LOAD;
      end
      w_squash     = (w_path == PATH_LOAD) && squash_stat(M_icode, e_Cnd, d_stat);
      w_inc_bubble = !reset && (w_path == PATH_BUBBLE);
      w_inc_stall  = !reset && (w_path == PATH_STALL);
      w_inc_squash = !reset && w_squash;
   end

   // Compute the next E contents for the selected path
   always_comb begin
      w_next_stat  = STAT_AOK;
      w_next_icode = ICODE_NOP;
      w_next_ifun  = 4'h0;
      w_next_valC  = {W{1'b0}};
      w_next_valA  = {W{1'b0}};
      w_next_valB  = {W{1'b0}};
      w_next_dstE  = RNONE;
      w_next_dstM  = RNONE;
      w_next_srcA  = RNONE;
      w_next_srcB  = RNONE;
      w_next_valid = 1'b0;
      case (w_path)
         PATH_STALL: begin
            w_next_stat  = r_stat;
            w_next_icode = r_icode;
            w_next_ifun  = r_ifun;
            w_next_valC  = r_valC;
            w_next_valA  = r_valA;
            w_next_valB  = r_valB;
            w_next_dstE  = r_dstE;
            w_next_dstM  = r_dstM;
            w_next_srcA  = r_srcA;
            w_next_srcB  = r_srcB;
            w_next_valid = r_valid;
         end
         PATH_LOAD: begin
            w_next_stat  = w_squash ? STAT_AOK : d_stat;
            w_next_icode = d_icode;
            w_next_ifun  = d_ifun;
            w_next_valC  = d_valC;
            w_next_valA  = d_valA;
            w_next_valB  = d_valB;
            w_next_dstE  = d_dstE;
            w_next_dstM  = d_dstM;
            w_next_srcA  = d_srcA;
            w_next_srcB  = d_srcB;
            w_next_valid = 1'b1;
         end
         PATH_BUBBLE: begin
            w_next_valid = 1'b0;
         end
         default: begin
            w_next_valid = 1'b0;
         end
      endcase
   end

   // E register: reset loads the bubble state, otherwise take the next contents
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat  <= STAT_AOK;
         r_icode <= ICODE_NOP;
         r_ifun  <= 4'h0;
         r_valC  <= {W{1'b0}};
         r_valA  <= {W{1'b0}};
         r_valB  <= {W{1'b0}};
         r_dstE  <= RNONE;
         r_dstM  <= RNONE;
         r_srcA  <= RNONE;
         r_srcB  <= RNONE;
         r_valid <= 1'b0;
      end else begin
         r_stat  <= w_next_stat;
         r_icode <= w_next_icode;
         r_ifun  <= w_next_ifun;
         r_valC  <= w_next_valC;
         r_valA  <= w_next_valA;
         r_valB  <= w_next_valB;
         r_dstE  <= w_next_dstE;
         r_dstM  <= w_next_dstM;
         r_srcA  <= w_next_srcA;
         r_srcB  <= w_next_srcB;
         r_valid <= w_next_valid;
      end
   end

   assign E_stat  = r_stat;
   assign E_icode = r_icode;
   assign E_ifun  = r_ifun;
   assign E_valC  = r_valC;
   assign E_valA  = r_valA;
   assign E_valB  = r_valB;
   assign E_dstE  = r_dstE;
   assign E_dstM  = r_dstM;
   assign E_srcA  = r_srcA;
   assign E_srcB  = r_srcB;
   assign E_valid = r_valid;

   sat_counter #(.CW(CW)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_bubble),
      .count (bubble_cnt)
   );

   sat_counter #(.CW(CW)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_stall),
      .count (stall_cnt)
   );

   sat_counter #(.CW(CW)) u_squash_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_squash),
      .count (squash_cnt)
   );

endmodule
